// File: rtl/debounce_multi_pkg.sv
// Shared state encoding and counter-width helper for the multi-channel debouncer.
package debounce_multi_pkg;

  typedef enum logic [1:0] {
    ST_DBM_LOW,
    ST_DBM_RISE_WAIT,
    ST_DBM_HIGH,
    ST_DBM_FALL_WAIT
  } st_dbm_t;

  function automatic int cnt_width(input int delay);
    return $clog2(delay + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce FSM: level changes after DELAY_CYCLES+1 consecutive differing samples.
// Registered one-cycle rise/fall pulses; no backpressure.
module debounce_channel
  import debounce_multi_pkg::*;
#(
  parameter int DELAY_CYCLES = 50000,
  parameter int CNT_W        = cnt_width(DELAY_CYCLES)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sample_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DELAY_CYCLES - 1);

  st_dbm_t          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rise;
  logic             r_fall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_DBM_LOW;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        ST_DBM_LOW: begin
          if (sample_i) begin
            r_state <= ST_DBM_RISE_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_DBM_RISE_WAIT: begin
          if (!sample_i) begin
            r_state <= ST_DBM_LOW;
            r_cnt   <= '0;
          end else if (r_cnt == LP_LAST) begin
            r_state <= ST_DBM_HIGH;
            r_cnt   <= '0;
            r_rise  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DBM_HIGH: begin
          if (!sample_i) begin
            r_state <= ST_DBM_FALL_WAIT;
            r_cnt   <= '0;
          end
        end
        ST_DBM_FALL_WAIT: begin
          if (sample_i) begin
            r_state <= ST_DBM_HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == LP_LAST) begin
            r_state <= ST_DBM_LOW;
            r_cnt   <= '0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_DBM_LOW;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Decoded from the state register alone so the level never glitches.
  assign level_o = (r_state == ST_DBM_HIGH) || (r_state == ST_DBM_FALL_WAIT);
  assign rise_o  = r_rise;
  assign fall_o  = r_fall;

endmodule

// File: rtl/debounce_multi.sv
// N_CH independent debouncers; DEBOUNCE_MULTI_SYNC_EN adds a 2-flop input synchronizer (+2 cycles).
// Latency DELAY_CYCLES+1 samples per transition; no backpressure.
module debounce_multi
  import debounce_multi_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int DELAY_CYCLES = 50000,
  parameter int CNT_W        = cnt_width(DELAY_CYCLES)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] signal_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o
);

  logic [N_CH-1:0] w_sample;

`ifdef DEBOUNCE_MULTI_SYNC_EN
  logic [N_CH-1:0] r_sync1;
  logic [N_CH-1:0] r_sync2;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= signal_i;
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
`else
  assign w_sample = signal_i;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .DELAY_CYCLES(DELAY_CYCLES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .sample_i(w_sample[g]),
      .level_o (level_o[g]),
      .rise_o  (rise_o[g]),
      .fall_o  (fall_o[g])
    );
  end

endmodule
